i2s_frame_src: RTL

- Upstream stage of the I2S transmitter. Accepts stereo sample pairs from the demodulator output path through a valid/ready handshake and buffers them in a small FIFO.
- Generates the serial bit clock and word-select clock by dividing the master clock.
- Presents each left/right pair held stable for one full I2S frame, so the transmitter sees constant words on its left and right data inputs throughout both slots.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/sync_fifo.sv | 65 ++++++
 rtl/i2s_frame_src.sv | 96 +++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared defaults, stereo sample type and sizing helper for the I2S frame source
package i2s_pkg;

    localparam int DEF_DATA_RES  = 24;
    localparam int DEF_SLOT_BITS = 32;

    typedef struct packed {
        logic [DEF_DATA_RES-1:0] left;
        logic [DEF_DATA_RES-1:0] right;
    } stereo_sample_t;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered occupancy, no fall-through
module sync_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [level_width(DEPTH)-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = level_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (do_push && !do_pop) begin
                level <= level + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_frame_src.sv
// rtl/i2s_frame_src.sv - buffers stereo pairs and presents one pair per I2S frame with sclk/lrclk
module i2s_frame_src
    import i2s_pkg::*;
#(
    parameter int DATA_RES   = DEF_DATA_RES,
    parameter int SLOT_BITS  = DEF_SLOT_BITS,
    parameter int MCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               mclk,
    input  logic                               reset,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [DATA_RES-1:0]                s_ldata,
    input  logic [DATA_RES-1:0]                s_rdata,
    output logic                               o_sclk,
    output logic                               o_lrclk,
    output logic [DATA_RES-1:0]                o_ldin,
    output logic [DATA_RES-1:0]                o_rdin,
    output logic                               o_valid,
    output logic                               o_underrun,
    output logic [level_width(FIFO_DEPTH)-1:0] o_fifo_level
);

    localparam int HALF       = MCLK_DIV / 2;
    localparam int DIV_W      = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int W          = 2 * DATA_RES;

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_nxt;
    logic             div_tc;
    logic             fall;
    logic             boundary;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [W-1:0]     head;

    assign div_tc   = (div_cnt == DIV_W'(HALF - 1));
    assign fall     = div_tc && o_sclk;
    assign bit_nxt  = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
    assign boundary = fall && (bit_cnt == BIT_W'(FRAME_BITS - 1));
    assign s_ready  = !fifo_full && !reset;
    assign push     = s_valid && s_ready;
    assign pop      = boundary && !fifo_empty;

    sync_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (mclk),
        .reset   (reset),
        .push    (push),
        .wr_data ({s_ldata, s_rdata}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_fifo_level)
    );

    always_ff @(posedge mclk) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            o_sclk     <= 1'b0;
            o_lrclk    <= 1'b0;
            o_ldin     <= '0;
            o_rdin     <= '0;
            o_valid    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            div_cnt    <= div_tc ? '0 : div_cnt + DIV_W'(1);
            o_underrun <= boundary && fifo_empty;
            if (div_tc) begin
                o_sclk <= !o_sclk;
            end
            // lrclk follows the upcoming bit index so it moves with the sclk falling edge.
            if (fall) begin
                bit_cnt <= bit_nxt;
                o_lrclk <= (bit_nxt >= BIT_W'(SLOT_BITS));
            end
            // Words are frozen for a whole frame; an empty FIFO mutes the frame.
            if (boundary) begin
                o_valid <= !fifo_empty;
                o_ldin  <= fifo_empty ? '0 : head[W-1:DATA_RES];
                o_rdin  <= fifo_empty ? '0 : head[DATA_RES-1:0];
            end
        end
    end

endmodule
